// File: rtl/axis_frame_seq_pkg.sv
// Shared types, defaults and header legality rule for the AXI-Stream frame sequencer.
// The optional early-tlast check is enabled with the AXIS_FRAME_SEQ_LAST_CHECK_EN macro in the top.
package axis_frame_seq_pkg;

  localparam int unsigned DIM_W_DEF  = 13;
  localparam int unsigned DATA_W_DEF = 24;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_X  = 3'd1,
    HDR_Y  = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } seq_state_e;

  // A header is legal when both dimensions are non-zero and within their limits.
  function automatic logic hdr_legal(input int unsigned x, input int unsigned y,
                                     input int unsigned xmax, input int unsigned ymax);
    return (x != 0) && (y != 0) && (x <= xmax) && (y <= ymax);
  endfunction

endpackage

// File: rtl/axis_frame_xy_counter.sv
// Raster x/y position counter: x wraps at xsize-1 and carries into y.
// Exposes start-of-frame, end-of-line and end-of-frame flags for the current position.
module axis_frame_xy_counter
  import axis_frame_seq_pkg::*;
#(
  parameter int unsigned DIM_W = DIM_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             advance_i,
  input  logic [DIM_W-1:0] xsize_i,
  input  logic [DIM_W-1:0] ysize_i,
  output logic             sof_o,
  output logic             eol_o,
  output logic             eof_o
);

  logic [DIM_W-1:0] x_cnt_q, x_cnt_d;
  logic [DIM_W-1:0] y_cnt_q, y_cnt_d;

  assign sof_o = (x_cnt_q == '0) && (y_cnt_q == '0);
  assign eol_o = (x_cnt_q == xsize_i - DIM_W'(1));
  assign eof_o = eol_o && (y_cnt_q == ysize_i - DIM_W'(1));

  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (clear_i) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
    end else if (advance_i) begin
      if (eol_o) begin
        x_cnt_d = '0;
        y_cnt_d = y_cnt_q + DIM_W'(1);
      end else begin
        x_cnt_d = x_cnt_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
    end else begin
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
    end
  end

endmodule

// File: rtl/axis_frame_sequencer.sv
// Strips and validates the Xsize/Ysize header of a framed stream and forwards pixels with tuser/tlast.
// Optional: AXIS_FRAME_SEQ_LAST_CHECK_EN makes an early upstream tlast terminate the frame as an error.
module axis_frame_sequencer
  import axis_frame_seq_pkg::*;
#(
  parameter int unsigned XSIZE_MAX = 512,
  parameter int unsigned YSIZE_MAX = 512,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DIM_W     = DIM_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic              tvalid_i,
  output logic              tready_o,
  input  logic              tlast_i,
  input  logic [DATA_W-1:0] tdata_i,
  output logic              tvalid_o,
  input  logic              tready_i,
  output logic              tlast_o,
  output logic              tuser_o,
  output logic [DATA_W-1:0] tdata_o,
  output logic [DIM_W-1:0]  xsize_o,
  output logic [DIM_W-1:0]  ysize_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              hdr_err_o,
  output seq_state_e        state_o
);

  // Handshake: a beat transfers on any cycle where valid && ready are both high.
  // In STREAM, tvalid_o follows tvalid_i and tready_o follows tready_i; neither
  // output depends on the other, so no combinational ready->valid path exists.

  seq_state_e       state_q, state_d;
  logic [DIM_W-1:0] xsize_q, xsize_d;
  logic [DIM_W-1:0] ysize_q, ysize_d;

  logic in_beat;
  logic out_beat;
  logic hdr_ok;
  logic sof, eol, eof;
  logic early_last;

  assign in_beat  = tvalid_i && tready_o;
  assign out_beat = (state_q == STREAM) && tvalid_i && tready_i;
  assign hdr_ok   = hdr_legal(32'(xsize_q), 32'(tdata_i[DIM_W-1:0]), XSIZE_MAX, YSIZE_MAX);

`ifdef AXIS_FRAME_SEQ_LAST_CHECK_EN
  assign early_last = tlast_i && !eof;
`else
  logic unused_tlast;
  assign unused_tlast = tlast_i;
  assign early_last   = 1'b0;
`endif

  axis_frame_xy_counter #(
    .DIM_W (DIM_W)
  ) u_xy_counter (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (state_q != STREAM),
    .advance_i (out_beat),
    .xsize_i   (xsize_q),
    .ysize_i   (ysize_q),
    .sof_o     (sof),
    .eol_o     (eol),
    .eof_o     (eof)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      xsize_q <= '0;
      ysize_q <= '0;
    end else begin
      state_q <= state_d;
      xsize_q <= xsize_d;
      ysize_q <= ysize_d;
    end
  end

  always_comb begin
    state_d = state_q;
    xsize_d = xsize_q;
    ysize_d = ysize_q;
    unique case (state_q)
      IDLE: begin
        if (enable_i) state_d = HDR_X;
      end
      HDR_X: begin
        if (in_beat) begin
          xsize_d = tdata_i[DIM_W-1:0];
          state_d = HDR_Y;
        end
      end
      HDR_Y: begin
        if (in_beat) begin
          ysize_d = tdata_i[DIM_W-1:0];
          state_d = hdr_ok ? STREAM : ERR;
        end
      end
      STREAM: begin
        if (out_beat) begin
          if (eof)             state_d = DONE;
          else if (early_last) state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tready_o     = 1'b0;
    tvalid_o     = 1'b0;
    tdata_o      = '0;
    tlast_o      = 1'b0;
    tuser_o      = 1'b0;
    busy_o       = (state_q != IDLE);
    frame_done_o = (state_q == DONE);
    hdr_err_o    = (state_q == ERR);
    case (state_q)
      HDR_X, HDR_Y: tready_o = 1'b1;
      STREAM: begin
        tvalid_o = tvalid_i;
        tready_o = tready_i;
        tdata_o  = tdata_i;
        tlast_o  = eol || early_last;
        tuser_o  = sof;
      end
      default: ;
    endcase
  end

  assign xsize_o = xsize_q;
  assign ysize_o = ysize_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_axis_frame_sequencer.sv
// Bench for axis_frame_sequencer: directed and random frames scored against a frame-level model.
module tb_axis_frame_sequencer;
  import axis_frame_seq_pkg::*;

  logic        clk;
  logic        rst_n_i;
  logic        enable_i;
  logic        tvalid_i;
  logic        tready_o;
  logic        tlast_i;
  logic [23:0] tdata_i;
  logic        tvalid_o;
  logic        tready_i;
  logic        tlast_o;
  logic        tuser_o;
  logic [23:0] tdata_o;
  logic [12:0] xsize_o;
  logic [12:0] ysize_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        hdr_err_o;
  seq_state_e  dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  int ready_mode  = 0;
  int pat_idx     = 0;

  logic [25:0] exp_q[$];

  axis_frame_sequencer dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .enable_i     (enable_i),
    .tvalid_i     (tvalid_i),
    .tready_o     (tready_o),
    .tlast_i      (tlast_i),
    .tdata_i      (tdata_i),
    .tvalid_o     (tvalid_o),
    .tready_i     (tready_i),
    .tlast_o      (tlast_o),
    .tuser_o      (tuser_o),
    .tdata_o      (tdata_o),
    .xsize_o      (xsize_o),
    .ysize_o      (ysize_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .hdr_err_o    (hdr_err_o),
    .state_o      (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every downstream beat must match the head of the expected queue.
  always @(negedge clk) begin
    logic [25:0] e;
    if (rst_n_i === 1'b1 && tvalid_o === 1'b1) begin
      check("tready_mirror", 32'(tready_o), 32'(tready_i));
      if (tready_i === 1'b1) begin
        check("beat_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat", 32'({tuser_o, tlast_o, tdata_o}), 32'(e));
        end
      end
    end
  end

  task automatic set_ready();
    case (ready_mode)
      0: tready_i = 1'b1;
      1: begin
        tready_i = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
        pat_idx++;
      end
      default: tready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Driver: present one word and hold it until it is accepted.
  task automatic push_word(input logic [23:0] w, input logic last);
    int   guard;
    logic hs;
    tvalid_i = 1'b1;
    tdata_i  = w;
    tlast_i  = last;
    guard    = 0;
    hs       = 1'b0;
    do begin
      set_ready();
      @(negedge clk);
      hs = (tready_o === 1'b1);
      @(posedge clk);
      #1;
      guard++;
    end while (!hs && guard < 200);
    check("handshake", 32'(hs), 32'd1);
    tvalid_i = 1'b0;
    tlast_i  = 1'b0;
  endtask

  // Frame-level reference: header legality from the size rules, then raster markers per pixel index.
  task automatic run_frame(input int x, input int y, input int mode, input int early_k, input bit seq);
    int          n, stop, ndone, nerr;
    bit          legal, early_err;
    logic [23:0] d;
    logic        tu, tl;
    legal      = (x >= 1) && (x <= 512) && (y >= 1) && (y <= 512);
    ready_mode = mode;
    pat_idx    = 0;
    enable_i   = 1'b1;
    push_word(24'(x), 1'b0);
    push_word(24'(y), 1'b0);
    enable_i = 1'b0;
    check("xsize_latch", 32'(xsize_o), 32'(x));
    check("ysize_latch", 32'(ysize_o), 32'(y));
    early_err = 1'b0;
    n         = legal ? x * y : 0;
    stop      = n;
`ifdef AXIS_FRAME_SEQ_LAST_CHECK_EN
    if (legal && early_k >= 0 && early_k < n - 1) begin
      stop      = early_k + 1;
      early_err = 1'b1;
    end
`endif
    for (int i = 0; i < stop; i++) begin
      d  = seq ? 24'(i + 1) : 24'($urandom);
      tu = (i == 0);
      tl = ((i % x) == x - 1) || (early_err && i == early_k);
      exp_q.push_back({tu, tl, d});
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        tvalid_i = 1'b0;
        @(posedge clk);
        #1;
      end
      push_word(d, ((i % x) == x - 1) || (i == early_k));
    end
    ndone = 0;
    nerr  = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ndone += int'(frame_done_o);
      nerr  += int'(hdr_err_o);
    end
    check("frame_done_pulses", 32'(ndone), 32'(legal && !early_err));
    check("hdr_err_pulses", 32'(nerr), 32'(!legal || early_err));
    check("busy_after", 32'(busy_o), 32'd0);
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] d;
    rst_n_i  = 1'b0;
    enable_i = 1'b0;
    tvalid_i = 1'b0;
    tlast_i  = 1'b0;
    tdata_i  = '0;
    tready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready_o", 32'(tready_o), 32'd0);
    check("rst_tvalid_o", 32'(tvalid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(frame_done_o), 32'd0);
    check("rst_err", 32'(hdr_err_o), 32'd0);
    check("rst_xsize", 32'(xsize_o), 32'd0);
    check("rst_ysize", 32'(ysize_o), 32'd0);
    rst_n_i = 1'b1;
    tvalid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_enable_busy", 32'(busy_o), 32'd0);
    check("idle_no_enable_tready", 32'(tready_o), 32'd0);
    tvalid_i = 1'b0;

    run_frame(4, 3, 0, -1, 1'b1);
    run_frame(0, 5, 0, -1, 1'b0);
    run_frame(2, 2, 0, -1, 1'b0);
    run_frame(513, 2, 0, -1, 1'b0);
    run_frame(3, 2, 1, -1, 1'b1);
    run_frame(1, 1, 0, -1, 1'b0);
    run_frame(4, 2, 0, 2, 1'b1);
    run_frame(2, 600, 2, -1, 1'b0);
    run_frame(512, 1, 2, -1, 1'b0);
    run_frame(1, 512, 0, -1, 1'b0);

    for (int f = 0; f < 12; f++) begin
      int rx, ry, ek;
      rx = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      ry = int'($urandom_range(1, 4));
      ek = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
      run_frame(rx, ry, int'($urandom_range(0, 2)), ek, 1'b0);
    end

    // Reset in the middle of a 4x4 frame after five pixels.
    ready_mode = 0;
    enable_i   = 1'b1;
    push_word(24'd4, 1'b0);
    push_word(24'd4, 1'b0);
    enable_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 24'($urandom);
      exp_q.push_back({(i == 0), ((i % 4) == 3), d});
      push_word(d, 1'b0);
    end
    rst_n_i  = 1'b0;
    tvalid_i = 1'b1;
    tdata_i  = 24'hA5A5A5;
    @(posedge clk);
    #1;
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_tvalid_o", 32'(tvalid_o), 32'd0);
    check("mid_rst_tready_o", 32'(tready_o), 32'd0);
    check("mid_rst_tuser", 32'(tuser_o), 32'd0);
    check("mid_rst_tlast", 32'(tlast_o), 32'd0);
    check("mid_rst_tdata", 32'(tdata_o), 32'd0);
    check("mid_rst_xsize", 32'(xsize_o), 32'd0);
    check("mid_rst_ysize", 32'(ysize_o), 32'd0);
    check("mid_rst_done", 32'(frame_done_o), 32'd0);
    check("mid_rst_err", 32'(hdr_err_o), 32'd0);
    check("mid_rst_drained", 32'(exp_q.size()), 32'd0);
    tvalid_i = 1'b0;
    rst_n_i  = 1'b1;
    @(posedge clk);
    #1;

    run_frame(2, 3, 2, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
